// File: rtl/mac_accumulator_block.sv
// Four-word accumulator behind the MAC combiner. Lanes of 1, 2 or 4 words share carries by mode.
// Optional build macro MAC_ACC_SATURATE_EN: clamp lanes on signed overflow instead of wrapping.
module mac_accumulator_block #(
   parameter int MAC_CONF_WIDTH = 3,
   parameter int MAC_MIN_WIDTH  = 8,
   parameter int MAC_ACC_WIDTH  = 4*MAC_MIN_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [MAC_CONF_WIDTH-1:0] cfg,
   input  logic                      in_valid,
   input  logic [MAC_ACC_WIDTH-1:0]  in0,
   input  logic [MAC_ACC_WIDTH-1:0]  in1,
   input  logic [MAC_ACC_WIDTH-1:0]  in2,
   input  logic [MAC_ACC_WIDTH-1:0]  in3,
   input  logic                      init_load,
   input  logic [MAC_ACC_WIDTH-1:0]  init0,
   input  logic [MAC_ACC_WIDTH-1:0]  init1,
   input  logic [MAC_ACC_WIDTH-1:0]  init2,
   input  logic [MAC_ACC_WIDTH-1:0]  init3,
   input  logic                      acc_clear,
   output logic                      out_valid,
   output logic [MAC_ACC_WIDTH-1:0]  out0,
   output logic [MAC_ACC_WIDTH-1:0]  out1,
   output logic [MAC_ACC_WIDTH-1:0]  out2,
   output logic [MAC_ACC_WIDTH-1:0]  out3,
   output logic [3:0]                ovf
);

   localparam int W = MAC_ACC_WIDTH;

   // Mode encodings match mac_const.vh; 2'b11 is treated as quad.
   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_DUAL   = 2'b01;

   // Index of the top word of the lane that word i belongs to.
   function automatic logic [1:0] lane_top(input logic [1:0] mode, input logic [1:0] i);
      case (mode)
         MODE_SINGLE: lane_top = i;
         MODE_DUAL:   lane_top = {i[1], 1'b1};
         default:     lane_top = 2'd3;
      endcase
   endfunction

   // Word-level slice of the lane-wide clamp value.
   function automatic logic [W-1:0] sat_word(input logic is_top, input logic neg);
      if (is_top) sat_word = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else        sat_word = neg ? {W{1'b0}} : {W{1'b1}};
   endfunction

   logic [W-1:0] r_acc [4];
   logic         r_out_valid;
   logic [3:0]   r_ovf;
   logic [1:0]   r_mode;

   logic [W-1:0] w_in   [4];
   logic [W-1:0] w_init [4];
   logic [W-1:0] w_base [4];
   logic [W-1:0] w_sum  [4];
   logic [W-1:0] w_res  [4];
   logic [W-1:0] w_next [4];
   logic [3:0]   w_cout;
   logic [3:0]   w_link;
   logic [3:0]   w_top;
   logic [3:0]   w_new_ovf;
   logic [1:0]   w_mode;
   logic         w_ovf_clr;

   assign w_mode    = cfg[1:0];
   assign w_ovf_clr = init_load | acc_clear | (w_mode != r_mode);

   assign w_in[0]   = in0;
   assign w_in[1]   = in1;
   assign w_in[2]   = in2;
   assign w_in[3]   = in3;
   assign w_init[0] = init0;
   assign w_init[1] = init1;
   assign w_init[2] = init2;
   assign w_init[3] = init3;

   // Carry enters word i only when word i-1 sits in the same lane.
   always_comb begin
      w_link = 4'b0000;
      for (int i = 1; i < 4; i++) begin
         w_link[i] = (lane_top(w_mode, 2'(i)) == lane_top(w_mode, 2'(i-1)));
      end
   end

   always_comb begin
      logic [W:0] t;
      logic       cin;
      w_cout    = 4'b0000;
      w_top     = 4'b0000;
      w_new_ovf = 4'b0000;
      t         = '0;
      for (int i = 0; i < 4; i++) begin
         w_base[i] = init_load ? w_init[i] : (acc_clear ? {W{1'b0}} : r_acc[i]);
         cin       = (i == 0) ? 1'b0 : (w_link[i] & w_cout[(i == 0) ? 0 : i-1]);
         t         = {1'b0, w_base[i]} + {1'b0, w_in[i]} + {{W{1'b0}}, cin};
         w_sum[i]  = t[W-1:0];
         w_cout[i] = t[W];
         w_top[i]  = (lane_top(w_mode, 2'(i)) == 2'(i));
         // Signed overflow is judged on the lane's top word only.
         w_new_ovf[i] = w_top[i] & cfg[2] & in_valid &
                        (w_base[i][W-1] == w_in[i][W-1]) &
                        (w_sum[i][W-1] != w_base[i][W-1]);
      end
   end

   always_comb begin
      logic [1:0] top;
      top = 2'd0;
      for (int i = 0; i < 4; i++) begin
         top = lane_top(w_mode, 2'(i));
`ifdef MAC_ACC_SATURATE_EN
         w_res[i] = w_new_ovf[top] ? sat_word(w_top[i], w_base[top][W-1]) : w_sum[i];
`else
         w_res[i] = w_sum[i];
`endif
         if (in_valid) w_next[i] = cfg[2] ? w_res[i] : w_in[i];
         else          w_next[i] = w_base[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) r_acc[i] <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 4'b0000;
         r_mode      <= MODE_SINGLE;
      end else if (en) begin
         for (int i = 0; i < 4; i++) r_acc[i] <= w_next[i];
         r_out_valid <= in_valid;
         r_ovf       <= (w_ovf_clr ? 4'b0000 : r_ovf) | w_new_ovf;
         r_mode      <= w_mode;
      end else begin
         r_out_valid <= 1'b0;
      end
   end

   assign out0      = r_acc[0];
   assign out1      = r_acc[1];
   assign out2      = r_acc[2];
   assign out3      = r_acc[3];
   assign out_valid = r_out_valid;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_mac_accumulator_block.sv
// Directed bench for mac_accumulator_block; expectations follow the build's saturation macro.
module tb_mac_accumulator_block;

   logic        clk = 1'b0;
   logic        rst, en, in_valid, init_load, acc_clear;
   logic [2:0]  cfg;
   logic [31:0] in0, in1, in2, in3, init0, init1, init2, init3;
   logic        out_valid;
   logic [31:0] out0, out1, out2, out3;
   logic [3:0]  ovf;

   int total = 0;
   int passed = 0;

   mac_accumulator_block dut (
      .clk(clk), .rst(rst), .en(en), .cfg(cfg), .in_valid(in_valid),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .init_load(init_load), .init0(init0), .init1(init1), .init2(init2), .init3(init3),
      .acc_clear(acc_clear), .out_valid(out_valid),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; init_load = 0; acc_clear = 0;
      in0 = 0; in1 = 0; in2 = 0; in3 = 0;
      init0 = 0; init1 = 0; init2 = 0; init3 = 0;
   endtask

   task automatic test_reset();
      rst = 1; en = 1; cfg = 3'b100; idle();
      step(); step();
      rst = 0;
      total++;
      if ({out0, out1, out2, out3} !== 128'd0) $display("FAIL reset_out got %h exp 0", {out0, out1, out2, out3});
      else passed++;
      total++;
      if ({out_valid, ovf} !== 5'd0) $display("FAIL reset_ctl got valid=%b ovf=%b exp 0/0000", out_valid, ovf);
      else passed++;
   endtask

   task automatic test_single_accum();
      logic [31:0] exp_v [3];
      exp_v[0] = 32'd5; exp_v[1] = 32'd10; exp_v[2] = 32'd15;
      cfg = 3'b100; idle(); acc_clear = 1;
      step();
      idle(); in_valid = 1; in0 = 32'd5;
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (out0 !== exp_v[k] || out_valid !== 1'b1)
            $display("FAIL single_acc%0d got out0=%0d valid=%b exp %0d/1", k, out0, out_valid, exp_v[k]);
         else passed++;
      end
      total++;
      if ({out1, out2, out3} !== 96'd0) $display("FAIL single_upper got %h exp 0", {out1, out2, out3});
      else passed++;
      idle();
   endtask

   task automatic test_dual_carry();
      cfg = 3'b101; idle();
      init_load = 1; init0 = 32'hFFFFFFFF; in_valid = 1; in0 = 32'd1;
      step();
      total++;
      if (out0 !== 32'd0 || out1 !== 32'd1 || ovf !== 4'b0000)
         $display("FAIL dual_carry got out0=%h out1=%h ovf=%b exp 0/1/0000", out0, out1, ovf);
      else passed++;
      cfg = 3'b100;
      step();
      total++;
      if (out0 !== 32'd0 || out1 !== 32'd0)
         $display("FAIL single_nocarry got out0=%h out1=%h exp 0/0", out0, out1);
      else passed++;
      // Carry from the low word pushes the dual lane's top word past max positive.
      cfg = 3'b101; init0 = 32'hFFFFFFFF; init1 = 32'h7FFFFFFF;
      step();
      total++;
`ifdef MAC_ACC_SATURATE_EN
      if (out0 !== 32'hFFFFFFFF || out1 !== 32'h7FFFFFFF || ovf !== 4'b0010)
         $display("FAIL dual_ovf got out0=%h out1=%h ovf=%b exp ffffffff/7fffffff/0010", out0, out1, ovf);
`else
      if (out0 !== 32'd0 || out1 !== 32'h80000000 || ovf !== 4'b0010)
         $display("FAIL dual_ovf got out0=%h out1=%h ovf=%b exp 0/80000000/0010", out0, out1, ovf);
`endif
      else passed++;
      idle();
   endtask

   task automatic test_quad_carry();
      cfg = 3'b110; idle();
      init_load = 1; init0 = 32'hFFFFFFFF; init1 = 32'hFFFFFFFF; init2 = 32'hFFFFFFFF;
      in_valid = 1; in0 = 32'd1;
      step();
      total++;
      if ({out3, out2, out1, out0} !== {32'd1, 96'd0} || ovf !== 4'b0000)
         $display("FAIL quad_carry got %h ovf=%b exp 1_0_0_0/0000", {out3, out2, out1, out0}, ovf);
      else passed++;
      idle();
   endtask

   task automatic test_overflow();
      cfg = 3'b100; idle();
      init_load = 1; init0 = 32'h7FFFFFFF; in_valid = 1; in0 = 32'd1;
      step();
      total++;
`ifdef MAC_ACC_SATURATE_EN
      if (out0 !== 32'h7FFFFFFF || ovf !== 4'b0001)
         $display("FAIL single_ovf got out0=%h ovf=%b exp 7fffffff/0001", out0, ovf);
`else
      if (out0 !== 32'h80000000 || ovf !== 4'b0001)
         $display("FAIL single_ovf got out0=%h ovf=%b exp 80000000/0001", out0, ovf);
`endif
      else passed++;
      idle(); acc_clear = 1;
      step();
      total++;
      if (ovf !== 4'b0000 || out0 !== 32'd0 || out_valid !== 1'b0)
         $display("FAIL clear_ovf got ovf=%b out0=%h valid=%b exp 0000/0/0", ovf, out0, out_valid);
      else passed++;
      idle();
   endtask

   task automatic test_clear_beat_and_hold();
      cfg = 3'b100; idle();
      acc_clear = 1; in_valid = 1; in0 = 32'd100;
      step();
      in0 = 32'd7;
      step();
      total++;
      if (out0 !== 32'd7 || out_valid !== 1'b1)
         $display("FAIL clear_beat got out0=%0d valid=%b exp 7/1", out0, out_valid);
      else passed++;
      en = 0; acc_clear = 0; in_valid = 1; in0 = 32'd9;
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (out0 !== 32'd7 || out_valid !== 1'b0)
            $display("FAIL en_hold%0d got out0=%0d valid=%b exp 7/0", k, out0, out_valid);
         else passed++;
      end
      en = 1; idle();
   endtask

   task automatic test_pass_through();
      cfg = 3'b000; idle();
      in_valid = 1; in0 = 32'h7FFFFFFF; in1 = 32'd3;
      step();
      total++;
      if (out0 !== 32'h7FFFFFFF || out1 !== 32'd3 || ovf !== 4'b0000 || out_valid !== 1'b1)
         $display("FAIL pass_through got out0=%h out1=%h ovf=%b valid=%b exp 7fffffff/3/0000/1", out0, out1, ovf, out_valid);
      else passed++;
      idle(); cfg = 3'b100;
   endtask

   task automatic test_reset_mid();
      cfg = 3'b100; idle();
      acc_clear = 1; in_valid = 1; in0 = 32'd42;
      step();
      total++;
      if (out0 !== 32'd42) $display("FAIL pre_reset got out0=%0d exp 42", out0);
      else passed++;
      acc_clear = 0; in0 = 32'd3; rst = 1;
      step();
      rst = 0; idle();
      total++;
      if ({out0, out1, out2, out3} !== 128'd0 || out_valid !== 1'b0 || ovf !== 4'b0000)
         $display("FAIL mid_reset got out0=%0d valid=%b ovf=%b exp 0/0/0000", out0, out_valid, ovf);
      else passed++;
   endtask

   task automatic test_mode_change();
      cfg = 3'b100; idle();
      init_load = 1; init0 = 32'h7FFFFFFF; in_valid = 1; in0 = 32'd1;
      step();
      total++;
      if (ovf !== 4'b0001) $display("FAIL mode_pre_ovf got ovf=%b exp 0001", ovf);
      else passed++;
      idle(); cfg = 3'b101;
      step();
      total++;
`ifdef MAC_ACC_SATURATE_EN
      if (ovf !== 4'b0000 || out0 !== 32'h7FFFFFFF)
         $display("FAIL mode_change got ovf=%b out0=%h exp 0000/7fffffff", ovf, out0);
`else
      if (ovf !== 4'b0000 || out0 !== 32'h80000000)
         $display("FAIL mode_change got ovf=%b out0=%h exp 0000/80000000", ovf, out0);
`endif
      else passed++;
      idle();
   endtask

   initial begin
      test_reset();
      test_single_accum();
      test_dual_carry();
      test_quad_carry();
      test_overflow();
      test_clear_beat_and_hold();
      test_pass_through();
      test_reset_mid();
      test_mode_change();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
